// File: rtl/mem_port_arbiter.sv
// Three-port round-robin arbiter in front of one single-port synchronous RAM.
// Grants and the RAM command are combinational. Read data comes back one
// cycle later, flagged to the port that issued the read. A granted port can
// hold the memory for up to LOCK_MAX consecutive accesses for atomic sequences.
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            lock,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_d,
    input  logic [DATA_W-1:0]     mem_q
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t      state_reg, state_next;
    logic [1:0]       rr_ptr_reg, rr_ptr_next;
    logic [1:0]       lock_owner_reg, lock_owner_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic             rd_valid_reg, rd_valid_next;
    logic [1:0]       rd_owner_reg, rd_owner_next;

    logic             grant_any;
    logic [1:0]       winner;
    logic [1:0]       p0, p1, p2;

    // Per-port fields split out; index 3 is an unused zero entry so a 2-bit
    // index is always in range.
    logic [ADDR_W-1:0] port_addr  [4];
    logic [DATA_W-1:0] port_wdata [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            if (gi < 3) begin : g_real
                assign port_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
                assign port_wdata[gi] = wdata[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign port_addr[gi]  = '0;
                assign port_wdata[gi] = '0;
            end
        end
    endgenerate

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Winner selection: the lock owner exclusively while locked, otherwise the
    // first requester in round-robin order starting at rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        winner    = 2'd0;
        p0        = rr_ptr_reg;
        p1        = inc3(p0);
        p2        = inc3(p1);
        if (!rst_n) begin
            grant_any = 1'b0;
        end else if (state_reg == LOCKED) begin
            if (req[lock_owner_reg]) begin
                grant_any = 1'b1;
                winner    = lock_owner_reg;
            end
        end else if (req[p0]) begin
            grant_any = 1'b1;
            winner    = p0;
        end else if (req[p1]) begin
            grant_any = 1'b1;
            winner    = p1;
        end else if (req[p2]) begin
            grant_any = 1'b1;
            winner    = p2;
        end
    end

    assign gnt      = grant_any ? (3'b001 << winner) : 3'b000;
    assign mem_en   = grant_any;
    assign mem_we   = grant_any & we[winner];
    assign mem_addr = grant_any ? port_addr[winner]  : '0;
    assign mem_d    = grant_any ? port_wdata[winner] : '0;

    assign rvalid   = rd_valid_reg ? (3'b001 << rd_owner_reg) : 3'b000;
    assign rdata    = rd_valid_reg ? mem_q : '0;

    // Next-state for lock FSM, round-robin pointer and read-return tracking.
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_owner_next = lock_owner_reg;
        lock_cnt_next   = lock_cnt_reg;
        rd_valid_next   = grant_any & ~we[winner];
        rd_owner_next   = (grant_any & ~we[winner]) ? winner : 2'd0;
        case (state_reg)
            UNLOCKED: begin
                if (grant_any) begin
                    if (lock[winner]) begin
                        state_next      = LOCKED;
                        lock_owner_next = winner;
                        lock_cnt_next   = CNT_W'(1);
                    end else begin
                        rr_ptr_next = inc3(winner);
                    end
                end
            end
            LOCKED: begin
                if (grant_any) begin
                    // Release on a plain access or when the hold budget is spent.
                    if (!lock[lock_owner_reg] ||
                        lock_cnt_reg >= CNT_W'(LOCK_MAX - 1)) begin
                        state_next    = UNLOCKED;
                        lock_cnt_next = '0;
                        rr_ptr_next   = inc3(lock_owner_reg);
                    end else begin
                        lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                    end
                end else begin
                    // Owner let go of req: everyone stays blocked this cycle.
                    state_next    = UNLOCKED;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = UNLOCKED;
                lock_cnt_next = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= UNLOCKED;
            rr_ptr_reg     <= 2'd0;
            lock_owner_reg <= 2'd0;
            lock_cnt_reg   <= '0;
            rd_valid_reg   <= 1'b0;
            rd_owner_reg   <= 2'd0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            rd_valid_reg   <= rd_valid_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scripted per-cycle stimulus with
// expected grants, plus a scoreboard of expected read returns.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 4;

    logic                clk;
    logic                rst_n;
    logic [2:0]          req, we, lock;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_d;
    logic [DATA_W-1:0]   mem_q;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .we      (we),
        .lock    (lock),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .mem_en  (mem_en),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_d   (mem_d),
        .mem_q   (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input int a);
        return (a == 'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
    endfunction

    // Single-port RAM with one-cycle registered read.
    logic [DATA_W-1:0] ram [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_d;
            else        mem_q <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)]
                                                            : init_val(int'(mem_addr));
        end
    end

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_exp_t;

    rd_exp_t           exp_q [$];
    logic [DATA_W-1:0] shadow [int];
    logic [ADDR_W-1:0] port_a [3];
    logic [DATA_W-1:0] port_d [3];
    int                cycle      = 0;
    int                assert_cnt = 0;
    int                fail_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock cycle: apply inputs, check the read return due now, check grant
    // and RAM command, and record the read response expected next cycle.
    task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                        input logic [2:0] exp_gnt);
        int           k;
        rd_exp_t      e;
        logic [DATA_W-1:0] ed;
        @(negedge clk);
        req   = r;
        we    = w;
        lock  = l;
        addr  = {port_a[2], port_a[1], port_a[0]};
        wdata = {port_d[2], port_d[1], port_d[0]};
        #1;
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e = exp_q.pop_front();
            check_val("rvalid", 64'(rvalid), 64'(3'b001 << e.port));
            check_val("rdata", 64'(rdata), 64'(e.data));
        end else begin
            check_val("rvalid_idle", 64'(rvalid), 64'(0));
            check_val("rdata_idle", 64'(rdata), 64'(0));
        end
        check_val("gnt", 64'(gnt), 64'(exp_gnt));
        k = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
        if (exp_gnt != 3'b000) begin
            check_val("mem_en", 64'(mem_en), 64'(1));
            check_val("mem_we", 64'(mem_we), 64'(w[k]));
            check_val("mem_addr", 64'(mem_addr), 64'(port_a[k]));
            check_val("mem_d", 64'(mem_d), 64'(port_d[k]));
            if (w[k]) begin
                shadow[int'(port_a[k])] = port_d[k];
            end else begin
                ed = shadow.exists(int'(port_a[k])) ? shadow[int'(port_a[k])]
                                                    : init_val(int'(port_a[k]));
                exp_q.push_back('{port: k, data: ed, due: cycle + 1});
            end
        end else begin
            check_val("mem_idle", 64'({mem_en, mem_we, mem_addr, mem_d}), 64'(0));
        end
        cycle++;
    endtask

    // Assert reset immediately, check outputs are quiet while requests are
    // pending, then release with no requests.
    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        req   = 3'b111;
        we    = 3'b000;
        lock  = 3'b000;
        #1;
        check_val("rst_gnt", 64'(gnt), 64'(0));
        check_val("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_d}), 64'(0));
        check_val("rst_rvalid", 64'(rvalid), 64'(0));
        @(negedge clk);
        check_val("rst_rvalid2", 64'(rvalid), 64'(0));
        check_val("rst_rdata", 64'(rdata), 64'(0));
        req   = 3'b000;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        port_a[0] = 14'h10; port_a[1] = 14'h10; port_a[2] = 14'h12;
        port_d[0] = 32'h0;  port_d[1] = 32'h0;  port_d[2] = 32'h0;
        do_reset();

        // Single read from port 1.
        step(3'b010, 3'b000, 3'b000, 3'b010);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // All ports read continuously from reset: 0,1,2,0,1,2.
        do_reset();
        port_a[0] = 14'h11; port_a[1] = 14'h10; port_a[2] = 14'h12;
        for (int i = 0; i < 6; i++) step(3'b111, 3'b000, 3'b000, 3'(3'b001 << (i % 3)));
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // Write by port 2 followed by a read of the same word by port 0.
        do_reset();
        port_a[1] = 14'h33;
        step(3'b010, 3'b000, 3'b000, 3'b010);
        port_a[0] = 14'h20; port_a[2] = 14'h20; port_d[2] = 32'h12345678;
        step(3'b101, 3'b100, 3'b000, 3'b100);
        step(3'b001, 3'b000, 3'b000, 3'b001);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // Port 1 holds the lock up to LOCK_MAX grants, then port 2 wins.
        do_reset();
        port_a[0] = 14'h1; port_a[1] = 14'h2; port_a[2] = 14'h3;
        step(3'b001, 3'b000, 3'b000, 3'b001);
        for (int i = 0; i < LOCK_MAX; i++) step(3'b111, 3'b000, 3'b010, 3'b010);
        step(3'b111, 3'b000, 3'b010, 3'b100);
        step(3'b111, 3'b000, 3'b000, 3'b001);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // Port 1 locks for two grants, releases on its third.
        do_reset();
        step(3'b001, 3'b000, 3'b000, 3'b001);
        step(3'b111, 3'b000, 3'b010, 3'b010);
        step(3'b111, 3'b000, 3'b010, 3'b010);
        step(3'b111, 3'b000, 3'b000, 3'b010);
        step(3'b111, 3'b000, 3'b000, 3'b100);
        step(3'b111, 3'b000, 3'b000, 3'b001);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // Owner drops req while locked: nobody granted that cycle, then unlocked.
        do_reset();
        step(3'b001, 3'b000, 3'b000, 3'b001);
        step(3'b111, 3'b010, 3'b010, 3'b010);
        step(3'b101, 3'b000, 3'b000, 3'b000);
        step(3'b101, 3'b000, 3'b000, 3'b100);
        // A lock input with no request is ignored.
        step(3'b000, 3'b000, 3'b111, 3'b000);
        step(3'b011, 3'b000, 3'b000, 3'b001);
        step(3'b011, 3'b000, 3'b000, 3'b010);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        // Reset right after a port 0 read grant: no rvalid, port 0 first again.
        do_reset();
        step(3'b010, 3'b000, 3'b000, 3'b010);
        step(3'b001, 3'b000, 3'b000, 3'b001);
        do_reset();
        step(3'b111, 3'b000, 3'b000, 3'b001);
        step(3'b111, 3'b000, 3'b000, 3'b010);
        step(3'b000, 3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000, 3'b000);

        check_val("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word RAM (1-cycle read latency, write-first not required) between three requesters: port 0 instruction fetch, port 1 CPU data, port 2 debug/loader.
- Sits between the CPU/debug logic and the RAM, which replaces the separate imem/dmem pair with one unified memory.
- Round-robin arbitration per cycle, with an optional bounded lock for atomic read-modify-write sequences.
- Returns read data to the owning port one cycle after grant.

Parameters:
ADDR_W, 14, word-address width
DATA_W, 32, data width
LOCK_MAX, 4, max consecutive grants a locking port may hold (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  3  per-port request; bit i = port i
we  in  3  per-port write enable, valid with req
lock  in  3  per-port lock request, valid with req
addr  in  3*ADDR_W  per-port word address, port i at [i*ADDR_W +: ADDR_W]
wdata  in  3*DATA_W  per-port write data
gnt  out  3  one-hot grant, combinational, same cycle as accepted request
rvalid  out  3  one-hot read-data valid, registered
rdata  out  DATA_W  read data, shared; valid for the port flagged in rvalid
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_d  out  DATA_W  RAM write data
mem_q  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Handshake:
  - A port raises req with we/addr/wdata/lock stable and holds them until it sees gnt[i]=1 in the same cycle.
  - The transfer is accepted on that rising edge.
  - Dropping req before gnt is legal (request withdrawn) and never corrupts state.
- Grant is combinational from req, lock_owner and rr_ptr. At most one gnt bit is set. gnt is 0 whenever req is 0.
- Memory command is combinational from the winner:
  - mem_en = |gnt; mem_we = we[winner]; mem_addr/mem_d = winner's fields.
  - When idle: mem_en=0, mem_we=0, mem_addr=0, mem_d=0.
- Round robin:
  - rr_ptr (2 bits, values 0..2) names the highest-priority port. Search order is rr_ptr, rr_ptr+1, rr_ptr+2, mod 3.
  - After any grant to port k without lock hold, rr_ptr <= (k+1) mod 3.
  - With no grant, rr_ptr is unchanged.
- Lock, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED when the granted port k has lock[k]=1. Then lock_owner <= k and lock_cnt <= 1.
  - While LOCKED with req[owner]=1, only the owner is granted and lock_cnt increments per grant. Other ports see gnt=0.
  - LOCKED -> UNLOCKED when any of these holds:
    - the owner is granted with lock[owner]=0;
    - the owner drops req for one cycle (no grant that cycle, others stay blocked that cycle);
    - lock_cnt reaches LOCK_MAX on a grant.
  - On a forced release at LOCK_MAX, rr_ptr <= (owner+1) mod 3, so another waiting port wins next cycle.
  - lock_cnt saturates at LOCK_MAX and never wraps.
- Read response:
  - A granted read (we=0) sets rvalid[k]=1 for exactly the next cycle, with rdata=mem_q in that cycle (rdata passes mem_q through, steered by a registered rd_owner).
  - Writes produce no rvalid.
  - Back-to-back reads from different ports give consecutive rvalid pulses with the correct owners.
  - When rvalid=0, rdata=0.
- Simultaneous events: a new grant and the rvalid of the previous read coexist in the same cycle, giving full throughput of one access per cycle.
- Reset, asynchronous, effective mid-operation:
  - rr_ptr=0, state UNLOCKED, lock_cnt=0, rvalid=0, rd_owner cleared.
  - A read granted in the cycle before reset asserts never produces rvalid.
  - All outputs are 0 during reset.
- Out of range: a lock input without req is ignored.

Test Plan:
- Single port 1 read, addr=0x10, RAM holds 0xDEADBEEF at 0x10: gnt=3'b010 the same cycle, rvalid=3'b010 and rdata=0xDEADBEEF the next cycle, mem_we=0.
- req=3'b111 every cycle from reset, all reads: grant order 0,1,2,0,1,2. rvalid follows one cycle behind in the same order, no idle cycles.
- Port 2 writes 0x12345678 to 0x20 while port 0 reads 0x20 in the following cycle (port 0 requesting both cycles): port 2 is granted first (rr_ptr=2 preset by a prior port 1 grant), and port 0 rdata=0x12345678.
- Port 1 requests with lock=1 continuously, with port 0 and port 2 requesting, LOCK_MAX=4: port 1 is granted 4 consecutive cycles, then port 2 is granted next and lock_cnt returns to 0.
- Port 1 locks for 2 grants, then drops lock on its 3rd: 3 grants to port 1, then round robin resumes at port 2.
- Assert rst_n=0 in the cycle right after a port 0 read grant: rvalid stays 0, and after release port 0 is granted first when all ports request.
